// File: rtl/clock_disp_pkg.sv
// Shared types, segment encodings and the BCD decode function for the display scanner.
package clock_disp_pkg;

    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned DIG_W      = 3;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned BCD_W      = 8;

    typedef logic [DIG_W-1:0] digit_t;
    typedef logic [SEG_W-1:0] seg_t;

    // Which time field a digit slot belongs to
    typedef enum logic [1:0] {
        FIELD_SEC  = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_HOUR = 2'd2
    } field_e;

    // One frame's worth of time, captured atomically
    typedef struct packed {
        logic [BCD_W-1:0] hour;
        logic [BCD_W-1:0] min;
        logic [BCD_W-1:0] sec;
    } time_t;

    // Active-high segment patterns, bit order gfedcba
    localparam seg_t SEG_0    = 7'h3F;
    localparam seg_t SEG_1    = 7'h06;
    localparam seg_t SEG_2    = 7'h5B;
    localparam seg_t SEG_3    = 7'h4F;
    localparam seg_t SEG_4    = 7'h66;
    localparam seg_t SEG_5    = 7'h6D;
    localparam seg_t SEG_6    = 7'h7D;
    localparam seg_t SEG_7    = 7'h07;
    localparam seg_t SEG_8    = 7'h7F;
    localparam seg_t SEG_9    = 7'h6F;
    localparam seg_t SEG_DASH = 7'h40;
    localparam seg_t SEG_OFF  = 7'h00;

    // Nibble to active-high segments; non-decimal nibbles show a dash
    function automatic seg_t bcd_to_seg(input logic [3:0] nib);
        seg_t seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

    // Digit slot to owning field: 0/1 seconds, 2/3 minutes, 4/5 hours
    function automatic field_e digit_field(input digit_t d);
        field_e f;
        case (d)
            3'd0, 3'd1: f = FIELD_SEC;
            3'd2, 3'd3: f = FIELD_MIN;
            default:    f = FIELD_HOUR;
        endcase
        return f;
    endfunction

    // Separator dots sit after the hour and minute ones digits (hh.mm.ss)
    function automatic logic digit_has_dp(input digit_t d);
        return (d == 3'd2) || (d == 3'd4);
    endfunction

endpackage

// File: rtl/clock_display_scan_if.sv
// Time/mode inputs from the clock control block and the multiplexed display drive.
interface clock_display_scan_if;
    import clock_disp_pkg::*;

    logic [BCD_W-1:0]      SECOND;
    logic [BCD_W-1:0]      MINUTE;
    logic [BCD_W-1:0]      HOUR;
    logic                  SET_SEC;
    logic                  SET_MIN;
    logic                  SET_HOUR;
    seg_t                  SEG;
    logic                  DP;
    logic [NUM_DIGITS-1:0] AN;

    // Clock control side: supplies time and mode, observes the display
    modport master (
        output SECOND, MINUTE, HOUR, SET_SEC, SET_MIN, SET_HOUR,
        input  SEG, DP, AN
    );

    // Scanner side: consumes time and mode, drives the display
    modport slave (
        input  SECOND, MINUTE, HOUR, SET_SEC, SET_MIN, SET_HOUR,
        output SEG, DP, AN
    );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational nibble-to-segment decoder with selectable output polarity.
module bcd_to_7seg
    import clock_disp_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nib,
    output seg_t       seg_c
);

    // Decode, then invert for common-anode panels
    always_comb begin
        seg_c = bcd_to_seg(nib);
        if (ACTIVE_LOW) begin
            seg_c = ~seg_c;
        end
    end

endmodule

// File: rtl/clock_display_scan.sv
// Six-digit multiplexed 7-segment scanner: per-frame time snapshot,
// inter-digit blanking gap and blinking of the field being set.
module clock_display_scan
    import clock_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYC    = 16,
    parameter int unsigned BLINK_TICKS  = 250,
    parameter int unsigned COMMON_ANODE = 1
) (
    input  logic CLK,
    input  logic RST_N,
    clock_display_scan_if.slave bus
);

    localparam int unsigned CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLK_W   = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam bit          ACT_LOW = (COMMON_ANODE != 0);

    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = ACT_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam seg_t                  SEG_IDLE = ACT_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic                  DP_IDLE  = ACT_LOW;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_TICKS - 1);
    localparam digit_t           DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt;
    digit_t                digit;
    logic [BLK_W-1:0]      blink_cnt;
    logic                  phase;
    time_t                 snap;

    logic                  tick_c;
    logic                  frame_end_c;
    logic [BCD_W-1:0]      field_val_c;
    logic                  field_set_c;
    logic [3:0]            nib_c;
    logic                  visible_c;
    logic [NUM_DIGITS-1:0] an_sel_c;
    seg_t                  dec_seg_c;

    logic [NUM_DIGITS-1:0] an_q;
    seg_t                  seg_q;
    logic                  dp_q;

    assign tick_c      = (cnt == CNT_LAST);
    assign frame_end_c = tick_c && (digit == DIG_LAST);

    // Slot prescaler and digit scan counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt   <= '0;
            digit <= '0;
        end else if (tick_c) begin
            cnt   <= '0;
            digit <= (digit == DIG_LAST) ? '0 : digit + DIG_W'(1);
        end else begin
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // Blink half-period counter and phase, advanced once per slot
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (tick_c) begin
            if (blink_cnt == BLK_LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + BLK_W'(1);
            end
        end
    end

    // Capture all three fields together as the scan wraps to digit 0
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            snap <= '0;
        end else if (frame_end_c) begin
            snap.hour <= bus.HOUR;
            snap.min  <= bus.MINUTE;
            snap.sec  <= bus.SECOND;
        end
    end

    // Select the current digit's nibble and its live set line
    always_comb begin
        field_val_c = '0;
        field_set_c = 1'b0;
        case (digit_field(digit))
            FIELD_SEC: begin
                field_val_c = snap.sec;
                field_set_c = bus.SET_SEC;
            end
            FIELD_MIN: begin
                field_val_c = snap.min;
                field_set_c = bus.SET_MIN;
            end
            FIELD_HOUR: begin
                field_val_c = snap.hour;
                field_set_c = bus.SET_HOUR;
            end
            default: begin
                field_val_c = '0;
                field_set_c = 1'b0;
            end
        endcase
        nib_c = digit[0] ? field_val_c[7:4] : field_val_c[3:0];
    end

    // Digit is lit outside the blanking gap unless its field is blinked off
    always_comb begin
        visible_c = (cnt >= CNT_BLANK)
                 && !(phase && field_set_c)
                 && (digit <= DIG_LAST);
        an_sel_c  = NUM_DIGITS'(1) << digit;
    end

    bcd_to_7seg #(
        .ACTIVE_LOW (ACT_LOW)
    ) u_dec (
        .nib   (nib_c),
        .seg_c (dec_seg_c)
    );

    // Registered display drive; everything idle when the digit is dark
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            an_q  <= AN_IDLE;
            seg_q <= SEG_IDLE;
            dp_q  <= DP_IDLE;
        end else if (visible_c) begin
            an_q  <= ACT_LOW ? ~an_sel_c : an_sel_c;
            seg_q <= dec_seg_c;
            dp_q  <= digit_has_dp(digit) ? ~DP_IDLE : DP_IDLE;
        end else begin
            an_q  <= AN_IDLE;
            seg_q <= SEG_IDLE;
            dp_q  <= DP_IDLE;
        end
    end

    assign bus.AN  = an_q;
    assign bus.SEG = seg_q;
    assign bus.DP  = dp_q;

endmodule

// File: tb/tb_clock_display_scan.sv
// Directed and randomized checks of the display scanner against a frame-level reference.
module tb_clock_display_scan;

    localparam int SD = 4;   // cycles per slot
    localparam int BL = 1;   // blank cycles per slot
    localparam int BT = 2;   // slot ticks per blink half-period

    logic CLK;
    logic RST_N;

    clock_display_scan_if bus ();

    clock_display_scan #(
        .SCAN_DIV     (SD),
        .BLANK_CYC    (BL),
        .BLINK_TICKS  (BT),
        .COMMON_ANODE (1)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference state: edges since reset release, and the time shown this frame
    int         n;
    logic [7:0] m_sec, m_min, m_hour;
    logic [5:0] prev_an;

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0: s = 7'h3F; 4'd1: s = 7'h06; 4'd2: s = 7'h5B; 4'd3: s = 7'h4F;
            4'd4: s = 7'h66; 4'd5: s = 7'h6D; 4'd6: s = 7'h7D; 4'd7: s = 7'h07;
            4'd8: s = 7'h7F; 4'd9: s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // One clock: predict the output from slot arithmetic, then compare
    task automatic cycle();
        int slot, pos, dig;
        bit ph, setf, vis;
        logic [7:0] fld;
        logic [3:0] nib;
        logic [5:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        slot = n / SD;
        pos  = n % SD;
        dig  = slot % 6;
        ph   = ((slot / BT) % 2) == 1;
        case (dig / 2)
            0:       begin fld = m_sec;  setf = bus.SET_SEC;  end
            1:       begin fld = m_min;  setf = bus.SET_MIN;  end
            default: begin fld = m_hour; setf = bus.SET_HOUR; end
        endcase
        nib   = (dig % 2 == 1) ? fld[7:4] : fld[3:0];
        vis   = (pos >= BL) && !(ph && setf);
        e_an  = vis ? ~(6'b000001 << dig) : 6'h3F;
        e_seg = vis ? ~ref_seg(nib) : 7'h7F;
        e_dp  = (vis && (dig == 2 || dig == 4)) ? 1'b0 : 1'b1;
        if (pos == SD - 1 && dig == 5) begin
            m_sec  = bus.SECOND;
            m_min  = bus.MINUTE;
            m_hour = bus.HOUR;
        end
        n++;
        @(posedge CLK);
        #1;
        checks++;
        assert (bus.AN === e_an) else begin
            errors++;
            $error("FAIL an n=%0d: got %b want %b", n, bus.AN, e_an);
        end
        checks++;
        assert (bus.SEG === e_seg) else begin
            errors++;
            $error("FAIL seg n=%0d: got %h want %h", n, bus.SEG, e_seg);
        end
        checks++;
        assert (bus.DP === e_dp) else begin
            errors++;
            $error("FAIL dp n=%0d: got %b want %b", n, bus.DP, e_dp);
        end
        checks++;
        assert ($countones(~bus.AN) <= 1) else begin
            errors++;
            $error("FAIL onehot n=%0d: got %b want at most one low bit", n, bus.AN);
        end
        if (prev_an != 6'h3F && bus.AN != 6'h3F) begin
            checks++;
            assert (bus.AN === prev_an) else begin
                errors++;
                $error("FAIL gap n=%0d: got %b after %b want an all-off cycle between digits", n, bus.AN, prev_an);
            end
        end
        prev_an = bus.AN;
    endtask

    // Run to a given edge count and compare against a hand-derived value
    task automatic spot(input string tag, input int at, input logic [5:0] an,
                        input logic [6:0] seg, input logic dp);
        while (n < at) cycle();
        checks++;
        assert ({bus.AN, bus.SEG, bus.DP} === {an, seg, dp}) else begin
            errors++;
            $error("FAIL %s: got AN=%b SEG=%h DP=%b want AN=%b SEG=%h DP=%b",
                   tag, bus.AN, bus.SEG, bus.DP, an, seg, dp);
        end
    endtask

    task automatic check_reset(input string tag);
        checks++;
        assert ({bus.AN, bus.SEG, bus.DP} === {6'h3F, 7'h7F, 1'b1}) else begin
            errors++;
            $error("FAIL %s: got AN=%b SEG=%h DP=%b want AN=111111 SEG=7f DP=1",
                   tag, bus.AN, bus.SEG, bus.DP);
        end
    endtask

    task automatic restart();
        n       = 0;
        m_sec   = 8'h00;
        m_min   = 8'h00;
        m_hour  = 8'h00;
        prev_an = 6'h3F;
    endtask

    initial begin
        RST_N        = 1'b0;
        bus.SECOND   = 8'h00;
        bus.MINUTE   = 8'h00;
        bus.HOUR     = 8'h00;
        bus.SET_SEC  = 1'b0;
        bus.SET_MIN  = 1'b0;
        bus.SET_HOUR = 1'b0;
        restart();

        // Reset values while held in reset
        repeat (2) @(posedge CLK);
        #1;
        check_reset("reset_hold");

        // Release; first frame still shows the zeroed snapshot
        bus.HOUR   = 8'h12;
        bus.MINUTE = 8'h34;
        bus.SECOND = 8'h56;
        RST_N      = 1'b1;
        spot("first_digit", 2, 6'h3E, 7'h40, 1'b1);

        // Second frame shows 12.34.56
        spot("s_ones",  26, 6'h3E, 7'h02, 1'b1);
        spot("s_tens",  30, 6'h3D, 7'h12, 1'b1);
        spot("m_ones",  34, 6'h3B, 7'h19, 1'b0);
        spot("m_tens",  38, 6'h37, 7'h30, 1'b1);
        spot("h_ones",  42, 6'h2F, 7'h24, 1'b0);
        spot("h_tens",  46, 6'h1F, 7'h79, 1'b1);
        spot("gap_off", 49, 6'h3F, 7'h7F, 1'b1);

        // Change SECOND mid-frame: held until the next frame
        while (n < 60) cycle();
        bus.SECOND = 8'h57;
        spot("snap_hold", 70, 6'h1F, 7'h79, 1'b1);
        spot("snap_new",  74, 6'h3E, 7'h78, 1'b1);
        spot("snap_tens", 78, 6'h3D, 7'h12, 1'b1);

        // Non-decimal minute ones nibble shows a dash
        while (n < 80) cycle();
        bus.MINUTE = 8'h3A;
        spot("dash",     106, 6'h3B, 7'h3F, 1'b0);
        spot("min_tens", 110, 6'h37, 7'h30, 1'b1);

        // Blink minutes, then minutes and hours together
        bus.SET_MIN = 1'b1;
        spot("blink_vis", 146, 6'h3E, 7'h78, 1'b1);
        spot("blink_min", 154, 6'h3F, 7'h7F, 1'b1);
        spot("blink_hrs_on", 162, 6'h2F, 7'h24, 1'b0);
        while (n < 206) cycle();
        bus.SET_HOUR = 1'b1;
        spot("blink_hour", 234, 6'h3F, 7'h7F, 1'b1);
        while (n < 302) cycle();
        bus.SET_MIN  = 1'b0;
        bus.SET_HOUR = 1'b0;

        // Ten frames of randomly changing time and mode inputs
        for (int i = 0; i < 240; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 5))
                    0: bus.SECOND   = 8'($urandom);
                    1: bus.MINUTE   = 8'($urandom);
                    2: bus.HOUR     = 8'($urandom);
                    3: bus.SET_SEC  = 1'($urandom);
                    4: bus.SET_MIN  = 1'($urandom);
                    default: bus.SET_HOUR = 1'($urandom);
                endcase
            end
            cycle();
        end

        // Asynchronous reset mid-slot, then scanning restarts from digit 0
        RST_N = 1'b0;
        #1;
        check_reset("reset_async");
        @(posedge CLK);
        #1;
        check_reset("reset_held_edge");
        RST_N = 1'b1;
        restart();
        spot("restart_digit", 2, 6'h3E, 7'h40, 1'b1);
        while (n < 30) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
